sevenseg_capture: RTL and testbench

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

---
 rtl/sevenseg_capture.sv | 139 +++++++++++++
 tb/tb_sevenseg_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: observes a multiplexed seven-segment display and rebuilds
// the displayed hex value. Each digit is accepted once its (select, segment)
// sample has stayed identical long enough. A frame is published once every
// digit position has been seen.
module sevenseg_capture #(
  parameter int NUM_DIGITS        = 4,
  parameter int ZERO_IS_ON        = 0,
  parameter int INVERSE_NUMBERING = 0,
  parameter int STABLE_CYCLES     = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [6:0]              in_leds,
  input  logic [NUM_DIGITS-1:0]   in_digit_sel,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic                    out_valid,
  output logic                    out_frame,
  output logic                    out_err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Segment patterns for hex digits 0..f, one table per bit ordering.
  localparam logic [6:0] TABLE0 [16] = '{
    7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
    7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
  localparam logic [6:0] TABLE1 [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  // Returns {hit, digit}. An exact match is required, so a partly lit or
  // ghosted pattern is reported as undecodable instead of being guessed.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    logic [6:0] entry;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      entry = (INVERSE_NUMBERING != 0) ? TABLE1[i] : TABLE0[i];
      if (seg == entry) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic [6:0]              leds_q, prev_leds;
  logic [NUM_DIGITS-1:0]   sel_q, prev_sel;
  logic [7:0]              cnt, cnt_next;
  logic                    committed, committed_next;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
  logic [NUM_DIGITS-1:0]   mask, mask_next;
  logic [6:0]              seg;
  logic                    onehot, same, commit, hit, full;
  logic [3:0]              digit;

  // Register the asynchronous display lines once; keep the previous sample
  // so that stability can be judged.
  // NOTE: sequential state uses non-blocking assignments. Every register
  // then updates from values taken before the edge, whatever order the
  // blocks are written in.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      leds_q    <= '0;
      sel_q     <= '0;
      prev_leds <= '0;
      prev_sel  <= '0;
    end else begin
      leds_q    <= in_leds;
      sel_q     <= in_digit_sel;
      prev_leds <= leds_q;
      prev_sel  <= sel_q;
    end
  end

  // Stability counting, commit decision and the next shadow/mask state.
  // NOTE: every signal gets a default first. A path that leaves a signal
  // unassigned would otherwise infer a latch.
  always_comb begin
    cnt_next       = '0;
    committed_next = 1'b0;
    commit         = 1'b0;
    shadow_next    = shadow;
    seg            = (ZERO_IS_ON != 0) ? ~leds_q : leds_q;
    {hit, digit}   = decode(seg);
    onehot         = $onehot(sel_q);
    same           = (sel_q == prev_sel) && (leds_q == prev_leds) && (cnt != 8'd0);
    full           = &mask;

    if (onehot) begin
      if (!same)             cnt_next = 8'd1;
      else if (cnt < STABLE) cnt_next = cnt + 8'd1;
      else                   cnt_next = cnt;
      commit         = (cnt_next == STABLE) && !(same && committed);
      committed_next = (same && committed) || commit;
    end

    // A frame completing on this edge clears the mask first, so a commit
    // on the same edge lands in the new frame and is not lost.
    mask_next = full ? '0 : mask;
    if (commit && hit) begin
      mask_next = mask_next | sel_q;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (sel_q[i]) shadow_next[4*i +: 4] = digit;
    end
  end

  // Stability counter and the flag that blocks repeated commits.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt       <= '0;
      committed <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      committed <= committed_next;
    end
  end

  // Frame assembly and publication. A partial frame is dropped on reset.
  // NOTE: the shadow store is a plain register that is explicitly reset,
  // so no stale digits can leak into the first frame after reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      shadow    <= '0;
      mask      <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
      out_frame <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      shadow    <= shadow_next;
      mask      <= mask_next;
      out_frame <= full;
      out_err   <= commit && !hit;
      if (full) begin
        out_value <= shadow;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Testbench for sevenseg_capture. Two instances are driven from the same
// logical digit stream. The first uses the default active-high segments and
// table 0. The second uses active-low segments and table 1. Both must
// rebuild the same value. A run-length reference model predicts every
// output on every cycle.
module tb_sevenseg_capture;

  localparam int N = 4;
  localparam int S = 4;
  localparam int BAD = 16;  // code for the undecodable pattern 7'h01

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   leds0, leds1;
  logic [N-1:0] sel;
  logic [4*N-1:0] value0, value1;
  logic         valid0, frame0, err0, valid1, frame1, err1;

  always #5 clk = ~clk;

  sevenseg_capture #(.NUM_DIGITS(N), .ZERO_IS_ON(0), .INVERSE_NUMBERING(0), .STABLE_CYCLES(S)) dut0 (
    .in_clk(clk), .in_rst(rst), .in_leds(leds0), .in_digit_sel(sel),
    .out_value(value0), .out_valid(valid0), .out_frame(frame0), .out_err(err0));

  sevenseg_capture #(.NUM_DIGITS(N), .ZERO_IS_ON(1), .INVERSE_NUMBERING(1), .STABLE_CYCLES(S)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_leds(leds1), .in_digit_sel(sel),
    .out_value(value1), .out_valid(valid1), .out_frame(frame1), .out_err(err1));

  logic [6:0] t0 [16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                          7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
  logic [6:0] t1 [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                          7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  int checks = 0;
  int errors = 0;
  int frames = 0;  // out_frame pulses seen on dut0 in the current scenario
  int errs   = 0;  // out_err pulses seen on dut0 in the current scenario

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. A digit is accepted when its sample has been seen
  // exactly S times in a row. That sample lands in the input register one
  // edge after it is driven, and it is committed on the following edge. A
  // frame is published on the edge after the last missing digit arrives.
  logic [N-1:0]   m_last_sel, pend_sel, m_mask;
  int             m_last_code, pend_code, run;
  bit             pend;
  logic [4*N-1:0] m_shadow, exp_value;
  logic           exp_valid, exp_frame, exp_err;

  task automatic model_reset();
    m_last_sel = '0; m_last_code = 0; run = 0; pend = 0;
    pend_sel = '0; pend_code = 0; m_mask = '0; m_shadow = '0;
    exp_value = '0; exp_valid = 0; exp_frame = 0; exp_err = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] s, input int code);
    exp_frame = (m_mask == '1);
    exp_err   = 0;
    if (exp_frame) begin
      exp_value = m_shadow;
      exp_valid = 1;
      m_mask    = '0;
    end
    if (pend) begin
      if (pend_code < 16) begin
        for (int i = 0; i < N; i++)
          if (pend_sel[i]) m_shadow[4*i +: 4] = pend_code[3:0];
        m_mask |= pend_sel;
      end else begin
        exp_err = 1;
      end
    end
    pend = 0;
    if ($countones(s) != 1) run = 0;
    else if (run > 0 && s == m_last_sel && code == m_last_code) run++;
    else run = 1;
    m_last_sel  = s;
    m_last_code = code;
    if (run == S) begin
      pend = 1; pend_sel = s; pend_code = code;
    end
  endtask

  task automatic compare_all(input string when);
    check({when, " value0"}, 32'(value0), 32'(exp_value));
    check({when, " valid0"}, 32'(valid0), 32'(exp_valid));
    check({when, " frame0"}, 32'(frame0), 32'(exp_frame));
    check({when, " err0"},   32'(err0),   32'(exp_err));
    check({when, " value1"}, 32'(value1), 32'(exp_value));
    check({when, " valid1"}, 32'(valid1), 32'(exp_valid));
    check({when, " frame1"}, 32'(frame1), 32'(exp_frame));
    check({when, " err1"},   32'(err1),   32'(exp_err));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check
  // at the next falling edge.
  task automatic cycle(input logic [N-1:0] s, input int code);
    sel   = s;
    leds0 = (code < 16) ? t0[code] : 7'h01;
    leds1 = ~((code < 16) ? t1[code] : 7'h01);
    @(posedge clk);
    model_edge(s, code);
    @(negedge clk);
    compare_all("cyc");
    if (frame0) frames++;
    if (err0)   errs++;
  endtask

  task automatic hold(input logic [N-1:0] s, input int code, input int n);
    for (int k = 0; k < n; k++) cycle(s, code);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sel = '0;
    model_reset();
    #1;
    compare_all("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    frames = 0;
    errs   = 0;
  endtask

  initial begin
    rst = 1'b1; sel = '0; leds0 = '0; leds1 = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Too short a hold, then blanking: nothing is committed. A frame that
    // then lacks digit 0 must not complete.
    hold(4'b0001, 5, 3);
    hold(4'b0000, 0, 5);
    check("short_no_err", 32'(errs), 0);
    hold(4'b0010, 1, 6); hold(4'b0100, 2, 6); hold(4'b1000, 3, 6);
    hold(4'b0000, 0, 3);
    check("short_no_frame", 32'(frames), 0);
    check("short_not_valid", 32'(valid0), 0);

    // Basic frame 3210.
    do_reset();
    hold(4'b0001, 0, 6); hold(4'b0010, 1, 6); hold(4'b0100, 2, 6); hold(4'b1000, 3, 6);
    hold(4'b0000, 0, 3);
    check("basic_frames", 32'(frames), 1);
    check("basic_value0", 32'(value0), 32'h3210);
    check("basic_value1", 32'(value1), 32'h3210);
    check("basic_valid", 32'(valid0), 1);

    // Frame dcba (table 1, active-low on dut1).
    frames = 0;
    hold(4'b0001, 10, 6); hold(4'b0010, 11, 6); hold(4'b0100, 12, 6); hold(4'b1000, 13, 6);
    hold(4'b0000, 0, 3);
    check("abcd_frames", 32'(frames), 1);
    check("abcd_value1", 32'(value1), 32'hdcba);
    check("abcd_value0", 32'(value0), 32'hdcba);

    // Undecodable pattern held long: exactly one error pulse, no frame.
    frames = 0; errs = 0;
    hold(4'b0100, BAD, 10);
    hold(4'b0000, 0, 2);
    check("bad_errs", 32'(errs), 1);
    check("bad_frames", 32'(frames), 0);
    check("bad_value_kept", 32'(value0), 32'hdcba);

    // Reset mid-frame discards the partial frame.
    do_reset();
    hold(4'b0001, 7, 6); hold(4'b0010, 7, 6);
    do_reset();
    hold(4'b0001, 4, 6); hold(4'b0010, 4, 6); hold(4'b0100, 4, 6); hold(4'b1000, 4, 6);
    hold(4'b0000, 0, 3);
    check("rst_frames", 32'(frames), 1);
    check("rst_value", 32'(value0), 32'h4444);

    // Multi-hot select held long acts as blanking.
    frames = 0; errs = 0;
    hold(4'b0011, 5, 20);
    check("multi_errs", 32'(errs), 0);
    check("multi_frames", 32'(frames), 0);
    check("multi_value", 32'(value0), 32'h4444);

    // Random holds of random samples, with occasional resets.
    for (int h = 0; h < 250; h++) begin
      logic [N-1:0] s;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      s = '0;
      else if (r == 1) s = 4'($urandom_range(0, 15));
      else             s = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) do_reset();
      hold(s, int'($urandom_range(0, 16)), int'($urandom_range(1, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
